// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
//   Shared definitions for the scan-to-UART sequencer: default widths, the
//   memory latency default, the latency counter width, and the FSM state type.
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int SCAN_ADDR_W  = 14;  // 16K-entry result/scan memory
    localparam int SCAN_DATA_W  = 8;   // memory / UART byte width
    localparam int SCAN_MEM_LAT = 1;   // default memory read latency (cycles)
    localparam int LAT_W        = 3;   // latency counter width, covers 0..7

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/scan_tx_ctrl.sv
// -----------------------------------------------------------------------------
// scan_tx_ctrl
//   Walks base_addr..base_addr+length-1 of the scan memory and streams each byte
//   to the UART transmitter over a valid/ready handshake. One start pulse in
//   IDLE runs a whole scan; done pulses once at the end.
//
// Optional feature: define SCAN_CHECKSUM_EN to append a mod-256 checksum byte
//   after the data bytes (tx_last then marks only the checksum byte).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin scan (sampled only in IDLE)
//   base_addr    first address, length = byte count (0 = empty scan)
//   read_select  memory read address;  read_data  memory read data
//   tx_data/tx_valid/tx_last  byte stream to UART;  tx_ready  UART accept
//   scan_start   1-cycle pulse after start accepted
//   busy         high from accepted start through the done pulse
//   done         1-cycle pulse at end of scan
// -----------------------------------------------------------------------------
module scan_tx_ctrl
    import scan_pkg::*;
#(
    parameter int ADDR_W  = SCAN_ADDR_W,
    parameter int DATA_W  = SCAN_DATA_W,
    parameter int MEM_LAT = SCAN_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] read_select,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              scan_start,
    output logic              busy,
    output logic              done
);

    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LAT);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    scan_state_t       state;
    logic [ADDR_W-1:0] cnt;   // bytes still to be handed to the UART
    logic [LAT_W-1:0]  lat;   // cycles read_select has been stable in ISSUE
`ifdef SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] sum;   // running mod-256 sum of accepted data bytes
`endif

    // NOTE: every register here is state, so all assignments are non-blocking;
    // reset is asynchronous and clears outputs the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat         <= '0;
            read_select <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            scan_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SCAN_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            scan_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        read_select <= base_addr;
                        cnt         <= length;
                        lat         <= '0;
                        scan_start  <= 1'b1;
                        busy        <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
                        sum         <= '0;
`endif
                        state       <= (length != '0) ? ST_ISSUE : ST_DONE;
                    end
                end

                // Hold the address MEM_LAT+1 cycles so read_data is settled
                // on the final edge, then present the byte.
                ST_ISSUE: begin
                    if (lat == LAT_LAST) begin
                        tx_data  <= read_data;
                        tx_valid <= 1'b1;
`ifdef SCAN_CHECKSUM_EN
                        tx_last  <= 1'b0;
`else
                        tx_last  <= (cnt == ONE);
`endif
                        state    <= ST_SEND;
                    end else begin
                        lat <= lat + 1'b1;
                    end
                end

                ST_SEND: begin
                    if (tx_valid && tx_ready) begin
                        cnt <= cnt - ONE;
                        if (cnt == ONE) begin
`ifdef SCAN_CHECKSUM_EN
                            // Checksum byte follows immediately; it includes
                            // the byte being accepted on this edge.
                            tx_data  <= sum + tx_data;
                            tx_valid <= 1'b1;
                            tx_last  <= 1'b1;
                            state    <= ST_CSUM;
`else
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
`endif
                        end else begin
`ifdef SCAN_CHECKSUM_EN
                            sum <= sum + tx_data;
`endif
                            tx_valid    <= 1'b0;
                            tx_last     <= 1'b0;
                            read_select <= read_select + ONE;  // wraps at 2^ADDR_W
                            lat         <= '0;
                            state       <= ST_ISSUE;
                        end
                    end
                end

                ST_CSUM: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end

                // An empty scan arrives here with done low: raise it for one
                // cycle first, so done always follows scan_start.
                ST_DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_tx_ctrl
//   Directed bench for scan_tx_ctrl with a 1-cycle-latency memory model.
//   Outputs are sampled on the falling edge; inputs change there as well.
// -----------------------------------------------------------------------------
module tb_scan_tx_ctrl;

`ifdef SCAN_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] base_addr;
    logic [13:0] length;
    logic [13:0] read_select;
    logic [7:0]  read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        scan_start;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:16383];
    logic [7:0]  got_data [$];
    logic        got_last [$];
    logic [13:0] got_addr [$];
    int          done_cyc;
    int          hs_cyc;
    int          stall_err;

    scan_tx_ctrl #(.ADDR_W(14), .DATA_W(8), .MEM_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .read_select(read_select),
        .read_data  (read_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .scan_start (scan_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory, one cycle of read latency.
    always @(posedge clk) read_data <= mem[read_select];

    // Expected stream: data bytes, then (checksum build, non-empty) the sum.
    function automatic int exp_count(input logic [13:0] l);
        return int'(l) + ((CSUM && l != 0) ? 1 : 0);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [13:0] b, input logic [13:0] l, input int i);
        logic [7:0] s;
        if (i < int'(l)) return mem[14'(b + 14'(i))];
        s = 8'h00;
        for (int k = 0; k < int'(l); k++) s = s + mem[14'(b + 14'(k))];
        return s;
    endfunction

    // Run one scan; record each byte at the falling edge before its handshake.
    // stall_idx: byte index held off stall_len cycles (-1 = none).
    // inject_cyc: cycle at which a second start is pulsed while busy (-1 = none).
    task automatic run_scan(input logic [13:0] b, input logic [13:0] l,
                            input int stall_idx, input int stall_len, input int inject_cyc);
        int         cyc;
        bit         stalled;
        logic [7:0] held_d;
        logic [13:0] held_rs;
        logic       held_l;
        got_data.delete(); got_last.delete(); got_addr.delete();
        done_cyc = -1; hs_cyc = -1; stall_err = 0; stalled = 0;
        @(negedge clk);
        base_addr = b; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        checks++;
        if (scan_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL scan_start_busy: got %b%b expected 11", scan_start, busy);
        end
        while (cyc < 400 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (start) start = 1'b0;
            if (cyc == inject_cyc) begin
                base_addr = 14'h0100; length = 14'd5; start = 1'b1;
            end
            if (cyc == 1) begin
                checks++;
                if (scan_start !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_start_width: got %b expected 0", scan_start);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else if (tx_valid === 1'b1) begin
                if (got_data.size() == stall_idx && !stalled) begin
                    stalled = 1;
                    held_d = tx_data; held_rs = read_select; held_l = tx_last;
                    tx_ready = 1'b0;
                    repeat (stall_len) begin
                        @(negedge clk);
                        cyc++;
                        if (tx_valid !== 1'b1 || tx_data !== held_d ||
                            read_select !== held_rs || tx_last !== held_l) stall_err++;
                    end
                    tx_ready = 1'b1;
                end
                got_data.push_back(tx_data);
                got_last.push_back(tx_last);
                got_addr.push_back(read_select);
                hs_cyc = cyc;
            end
        end
        start = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", cyc);
        end else begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_done: got busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({tx_valid, tx_last, tx_data, read_select, scan_start, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h rs=%h ss=%b b=%b dn=%b expected all 0",
                     tx_valid, tx_last, tx_data, read_select, scan_start, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_valid, busy, done, scan_start} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got v=%b b=%b dn=%b ss=%b expected 0",
                     tx_valid, busy, done, scan_start);
        end
    endtask

    task automatic test_basic();
        run_scan(14'h0010, 14'd4, -1, 0, -1);
        checks++;
        if (got_data.size() != exp_count(14'd4)) begin
            errors++;
            $display("FAIL basic_count: got %0d expected %0d", got_data.size(), exp_count(14'd4));
        end
        for (int i = 0; i < got_data.size() && i < exp_count(14'd4); i++) begin
            checks++;
            if (got_data[i] !== exp_byte(14'h0010, 14'd4, i) ||
                got_last[i] !== (i == exp_count(14'd4) - 1)) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h last=%b expected %h last=%b", i, got_data[i],
                         got_last[i], exp_byte(14'h0010, 14'd4, i), (i == exp_count(14'd4) - 1));
            end
        end
        // 3 cycles per byte (ISSUE x2 + SEND), done the cycle after the last handshake.
        checks++;
        if (done_cyc != 12 + (CSUM ? 1 : 0) || done_cyc != hs_cyc + 1) begin
            errors++;
            $display("FAIL basic_timing: got done at %0d last hs %0d expected %0d", done_cyc,
                     hs_cyc, 12 + (CSUM ? 1 : 0));
        end
    endtask

    task automatic test_backpressure();
        run_scan(14'h0030, 14'd5, 1, 20, -1);
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles expected 0", stall_err);
        end
        checks++;
        if (got_data.size() != exp_count(14'd5)) begin
            errors++;
            $display("FAIL bp_count: got %0d expected %0d", got_data.size(), exp_count(14'd5));
        end
        for (int i = 0; i < got_data.size() && i < exp_count(14'd5); i++) begin
            checks++;
            if (got_data[i] !== exp_byte(14'h0030, 14'd5, i)) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h expected %h", i, got_data[i], exp_byte(14'h0030, 14'd5, i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [13:0] addrs [4];
        addrs = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        run_scan(14'h3FFE, 14'd4, -1, 0, -1);
        checks++;
        if (got_data.size() != exp_count(14'd4)) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected %0d", got_data.size(), exp_count(14'd4));
        end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== addrs[i] || got_data[i] !== addrs[i][7:0]) begin
                errors++;
                $display("FAIL wrap_byte%0d: got addr %h data %h expected addr %h data %h", i,
                         got_addr[i], got_data[i], addrs[i], addrs[i][7:0]);
            end
        end
    endtask

    task automatic test_empty();
        run_scan(14'h0055, 14'd0, -1, 0, -1);
        checks++;
        if (got_data.size() != 0 || done_cyc != 1) begin
            errors++;
            $display("FAIL empty_scan: got %0d bytes done at %0d expected 0 bytes done at 1",
                     got_data.size(), done_cyc);
        end
    endtask

    task automatic test_busy_start();
        run_scan(14'h0020, 14'd3, -1, 0, 2);
        checks++;
        if (got_data.size() != exp_count(14'd3)) begin
            errors++;
            $display("FAIL busy_start_count: got %0d expected %0d", got_data.size(), exp_count(14'd3));
        end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== 14'h0020 + 14'(i) || got_data[i] !== 8'h20 + 8'(i)) begin
                errors++;
                $display("FAIL busy_start_byte%0d: got addr %h data %h expected addr %h", i,
                         got_addr[i], got_data[i], 14'h0020 + 14'(i));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got busy=%b valid=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int hs;
        bit hit;
        cyc = 0; hs = 0; hit = 0;
        @(negedge clk);
        base_addr = 14'h0080; length = 14'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 200 && !hit) begin
            @(negedge clk);
            cyc++;
            if (tx_valid === 1'b1) begin
                if (hs == 2) hit = 1;
                else hs++;
            end
        end
        checks++;
        if (!hit || tx_data !== 8'h82) begin
            errors++;
            $display("FAIL rst_mid_third_byte: got hit=%b data %h expected hit=1 data 82", hit, tx_data);
        end
        tx_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx_valid, tx_last, tx_data, read_select, scan_start, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v=%b d=%h rs=%h b=%b expected all 0",
                     tx_valid, tx_data, read_select, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        run_scan(14'h0080, 14'd3, -1, 0, -1);
        checks++;
        if (got_data.size() != exp_count(14'd3) || got_data[0] !== 8'h80) begin
            errors++;
            $display("FAIL rst_mid_rescan: got %0d bytes first %h expected %0d bytes first 80",
                     got_data.size(), got_data[0], exp_count(14'd3));
        end
    endtask

    task automatic test_checksum();
        logic [7:0] exp_d [4];
        logic       exp_l [4];
        int         n;
        mem[14'h0200] = 8'hF0; mem[14'h0201] = 8'h20; mem[14'h0202] = 8'h05;
        exp_d = '{8'hF0, 8'h20, 8'h05, 8'h15};
        exp_l = CSUM ? '{1'b0, 1'b0, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b1, 1'b0};
        n = CSUM ? 4 : 3;
        run_scan(14'h0200, 14'd3, -1, 0, -1);
        checks++;
        if (got_data.size() != n) begin
            errors++;
            $display("FAIL csum_count: got %0d expected %0d", got_data.size(), n);
        end
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL csum_byte%0d: got %h last=%b expected %h last=%b", i,
                         got_data[i], got_last[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
        base_addr = '0; length = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_empty();
        test_busy_start();
        test_reset_mid();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
